// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the iterative divider
package div_pkg;

    localparam int DIV_W     = 32;
    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = 6;

    // Quotient reported when the divisor is zero
    localparam logic [DIV_W-1:0] DBZ_QUOTIENT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Two's-complement negate when neg is set, pass-through otherwise
    function automatic logic [DIV_W-1:0] cond_negate(input logic [DIV_W-1:0] v,
                                                     input logic             neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_iter_step.sv
// rtl/div_iter_step.sv - one combinational restoring radix-2 division step
module div_iter_step
    import div_pkg::*;
(
    input  logic [DIV_W:0]   rem_in,
    input  logic [DIV_W-1:0] quo_in,
    input  logic [DIV_W-1:0] divisor,
    output logic [DIV_W:0]   rem_out,
    output logic [DIV_W-1:0] quo_out
);

    // One extra bit of headroom so the subtraction sign is unambiguous
    logic [DIV_W+1:0] rem_shift;
    logic [DIV_W+1:0] diff;

    // Shift in the next dividend bit, trial-subtract, restore on borrow
    always_comb begin
        rem_shift = {rem_in, quo_in[DIV_W-1]};
        diff      = rem_shift - {2'b00, divisor};
        if (!diff[DIV_W+1]) begin
            rem_out = diff[DIV_W:0];
            quo_out = {quo_in[DIV_W-2:0], 1'b1};
        end else begin
            rem_out = rem_shift[DIV_W:0];
            quo_out = {quo_in[DIV_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/iter_divider.sv
// rtl/iter_divider.sv - 32-bit iterative restoring divider, optional DIV_DBZ_FLAG_EN tuser flag
module iter_divider
    import div_pkg::*;
#(
    parameter int SIGNED = 0
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [DIV_W-1:0]     s_axis_dividend_tdata,
    input  logic                 s_axis_dividend_tvalid,
    output logic                 s_axis_dividend_tready,
    input  logic [DIV_W-1:0]     s_axis_divisor_tdata,
    input  logic                 s_axis_divisor_tvalid,
    output logic                 s_axis_divisor_tready,
`ifdef DIV_DBZ_FLAG_EN
    output logic                 m_axis_dout_tuser,
`endif
    output logic [2*DIV_W-1:0]   m_axis_dout_tdata,
    output logic                 m_axis_dout_tvalid
);

    localparam bit IS_SIGNED = (SIGNED != 0);

    div_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             dvd_cap, dvs_cap;
    logic [DIV_W-1:0] dvd_reg, dvs_reg;
    logic [DIV_W:0]   rem;
    logic [DIV_W-1:0] quo;
    logic [DIV_W-1:0] dvs_mag;
    logic [DIV_W:0]   step_rem;
    logic [DIV_W-1:0] step_quo;
    logic [2*DIV_W-1:0] dout_q;
    logic [2*DIV_W-1:0] result_nxt;

    logic             dvd_fire, dvs_fire, start, last_iter;
    logic [DIV_W-1:0] dvd_now, dvs_now;
    logic             dvd_neg_now, dvs_neg_now;
    logic             dvd_neg, dvs_neg, dvs_zero;

    assign dvd_fire  = s_axis_dividend_tvalid && s_axis_dividend_tready;
    assign dvs_fire  = s_axis_divisor_tvalid  && s_axis_divisor_tready;
    // Operands as they will look after this edge, whichever arrived first
    assign dvd_now   = dvd_cap ? dvd_reg : s_axis_dividend_tdata;
    assign dvs_now   = dvs_cap ? dvs_reg : s_axis_divisor_tdata;
    assign start     = (state == IDLE) && (dvd_cap || dvd_fire) && (dvs_cap || dvs_fire);
    assign last_iter = (state == RUN) && (cnt == CNT_W'(DIV_ITERS - 1));

    assign dvd_neg_now = IS_SIGNED && dvd_now[DIV_W-1];
    assign dvs_neg_now = IS_SIGNED && dvs_now[DIV_W-1];
    assign dvd_neg     = IS_SIGNED && dvd_reg[DIV_W-1];
    assign dvs_neg     = IS_SIGNED && dvs_reg[DIV_W-1];
    assign dvs_zero    = (dvs_reg == '0);

    assign m_axis_dout_tdata = dout_q;

    div_iter_step u_step (
        .rem_in  (rem),
        .quo_in  (quo),
        .divisor (dvs_mag),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt              = state;
        s_axis_dividend_tready = 1'b0;
        s_axis_divisor_tready  = 1'b0;
        m_axis_dout_tvalid     = 1'b0;
        case (state)
            IDLE: begin
                s_axis_dividend_tready = !dvd_cap;
                s_axis_divisor_tready  = !dvs_cap;
                if (start) state_nxt = RUN;
            end
            RUN: begin
                if (last_iter) state_nxt = DONE;
            end
            DONE: begin
                m_axis_dout_tvalid = 1'b1;
                state_nxt          = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture; flags drop when the run starts so tready returns after DONE
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dvd_cap <= 1'b0;
            dvs_cap <= 1'b0;
            dvd_reg <= '0;
            dvs_reg <= '0;
        end else begin
            if (dvd_fire) begin
                dvd_reg <= s_axis_dividend_tdata;
                dvd_cap <= 1'b1;
            end
            if (dvs_fire) begin
                dvs_reg <= s_axis_divisor_tdata;
                dvs_cap <= 1'b1;
            end
            if (start) begin
                dvd_cap <= 1'b0;
                dvs_cap <= 1'b0;
            end
        end
    end

    // Iteration datapath: load magnitudes on start, one step per RUN cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem     <= '0;
            quo     <= '0;
            dvs_mag <= '0;
            cnt     <= '0;
        end else if (start) begin
            rem     <= '0;
            quo     <= cond_negate(dvd_now, dvd_neg_now);
            dvs_mag <= cond_negate(dvs_now, dvs_neg_now);
            cnt     <= '0;
        end else if (state == RUN) begin
            rem     <= step_rem;
            quo     <= step_quo;
            cnt     <= cnt + CNT_W'(1);
        end
    end

    // Final result from the last step: sign fixup, or the divide-by-zero pattern
    always_comb begin
        result_nxt = '0;
        if (dvs_zero) begin
            result_nxt = {DBZ_QUOTIENT, dvd_reg};
        end else begin
            result_nxt = {cond_negate(step_quo, dvd_neg ^ dvs_neg),
                          cond_negate(step_rem[DIV_W-1:0], dvd_neg)};
        end
    end

    // Result register holds until the next completion
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)        dout_q <= '0;
        else if (last_iter) dout_q <= result_nxt;
    end

`ifdef DIV_DBZ_FLAG_EN
    assign m_axis_dout_tuser = (state == DONE) && dvs_zero;
`endif

endmodule

// File: tb/tb_iter_divider.sv
// tb/tb_iter_divider.sv - scoreboard bench for unsigned and signed iter_divider instances
module tb_iter_divider;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic [1:0][31:0] dvd_d, dvs_d;
    logic [1:0]       dvd_v, dvs_v, dvd_r, dvs_r, dout_v;
    logic [1:0][63:0] dout_d;
`ifdef DIV_DBZ_FLAG_EN
    logic [1:0]       dout_u;
`endif

    iter_divider #(.SIGNED(0)) u_divu (
        .clk                    (clk),
        .resetn                 (resetn),
        .s_axis_dividend_tdata  (dvd_d[0]),
        .s_axis_dividend_tvalid (dvd_v[0]),
        .s_axis_dividend_tready (dvd_r[0]),
        .s_axis_divisor_tdata   (dvs_d[0]),
        .s_axis_divisor_tvalid  (dvs_v[0]),
        .s_axis_divisor_tready  (dvs_r[0]),
`ifdef DIV_DBZ_FLAG_EN
        .m_axis_dout_tuser      (dout_u[0]),
`endif
        .m_axis_dout_tdata      (dout_d[0]),
        .m_axis_dout_tvalid     (dout_v[0])
    );

    iter_divider #(.SIGNED(1)) u_div (
        .clk                    (clk),
        .resetn                 (resetn),
        .s_axis_dividend_tdata  (dvd_d[1]),
        .s_axis_dividend_tvalid (dvd_v[1]),
        .s_axis_dividend_tready (dvd_r[1]),
        .s_axis_divisor_tdata   (dvs_d[1]),
        .s_axis_divisor_tvalid  (dvs_v[1]),
        .s_axis_divisor_tready  (dvs_r[1]),
`ifdef DIV_DBZ_FLAG_EN
        .m_axis_dout_tuser      (dout_u[1]),
`endif
        .m_axis_dout_tdata      (dout_d[1]),
        .m_axis_dout_tvalid     (dout_v[1])
    );

    typedef struct packed {
        logic [63:0] d;
        logic        z;
    } sb_t;

    sb_t         sb_q[$];
    int          checks;
    int          failures;
    int unsigned cyc = 0;
    logic [63:0] last_exp;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] model(input int inst, input logic [31:0] a, input logic [31:0] b);
        int sa, sb, q, r;
        if (b == 32'h0) return {32'hFFFF_FFFF, a};
        if (inst == 0) return {a / b, a % b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
        sa = a;
        sb = b;
        q  = sa / sb;
        r  = sa % sb;
        return {32'(q), 32'(r)};
    endfunction

    task automatic push(input logic [31:0] b, input logic [63:0] expv);
        sb_t e;
        e.d = expv;
        e.z = (b == 32'h0);
        sb_q.push_back(e);
    endtask

    task automatic drive(input int inst, input logic [31:0] a, input logic [31:0] b);
        dvd_d[inst] = a;
        dvs_d[inst] = b;
        dvd_v[inst] = 1'b1;
        dvs_v[inst] = 1'b1;
    endtask

    task automatic idle(input int inst);
        dvd_v[inst] = 1'b0;
        dvs_v[inst] = 1'b0;
    endtask

    // Called just after the second-capture edge; returns at the negedge of the DONE cycle
    task automatic wait_result(input int inst, input string tag, output int unsigned done_cyc);
        int  n;
        sb_t e;
        n = 61;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i == 1) check({tag, "_run_rdy"}, 64'({dvd_r[inst], dvs_r[inst]}), 64'd0);
            if (dout_v[inst]) begin
                n = i;
                break;
            end
        end
        done_cyc = cyc;
        check({tag, "_latency"}, 64'(n), 64'd33);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
            e.d = '0;
            e.z = 1'b0;
        end else begin
            e = sb_q.pop_front();
        end
        last_exp = e.d;
        check({tag, "_dout"}, dout_d[inst], e.d);
`ifdef DIV_DBZ_FLAG_EN
        check({tag, "_tuser"}, 64'(dout_u[inst]), 64'(e.z));
`endif
    endtask

    task automatic post_done(input int inst, input string tag);
        @(negedge clk);
        check({tag, "_valid_drop"}, 64'(dout_v[inst]), 64'd0);
        check({tag, "_rdy_back"}, 64'({dvd_r[inst], dvs_r[inst]}), 64'd3);
        check({tag, "_hold"}, dout_d[inst], last_exp);
    endtask

    task automatic op(input int inst, input logic [31:0] a, input logic [31:0] b,
                      input logic [63:0] expv, input string tag);
        int unsigned t;
        @(negedge clk);
        check({tag, "_rdy"}, 64'({dvd_r[inst], dvs_r[inst]}), 64'd3);
        drive(inst, a, b);
        push(b, expv);
        @(posedge clk);
        #1 idle(inst);
        wait_result(inst, tag, t);
        post_done(inst, tag);
    endtask

    initial begin
        int unsigned t, tprev;
        logic [31:0] ra, rb;
        logic [31:0] ba[3];
        logic [31:0] bb[3];
        bit          seen;

        checks   = 0;
        failures = 0;
        resetn   = 1'b0;
        dvd_d    = '0;
        dvs_d    = '0;
        dvd_v    = '0;
        dvs_v    = '0;
        last_exp = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_dvd_rdy", 64'(dvd_r), 64'd3);
        check("reset_dvs_rdy", 64'(dvs_r), 64'd3);
        check("reset_valid", 64'(dout_v), 64'd0);
        check("reset_dout_u", dout_d[0], 64'd0);
        check("reset_dout_s", dout_d[1], 64'd0);
        @(posedge clk);
        #1 resetn = 1'b1;

        op(0, 32'd100, 32'd7, 64'h0000000E_00000002, "u_100_7");
        op(1, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFD_FFFFFFFF, "s_m7_2");
        op(1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h80000000_00000000, "s_ovf");
        op(0, 32'h1234_5678, 32'd0, 64'hFFFFFFFF_12345678, "u_dbz");
        op(1, 32'h1234_5678, 32'd0, 64'hFFFFFFFF_12345678, "s_dbz");
        op(1, 32'hFFFF_FF9C, 32'd7, 64'hFFFFFFF2_FFFFFFFE, "s_m100_7");
        op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h00000001_00000000, "u_max");

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = (i < 3) ? $urandom_range(1, 5000) : $urandom;
            op(i % 2, ra, rb, model(i % 2, ra, rb), "rand");
        end

        // Staggered arrival with a re-offered dividend that must be ignored
        @(negedge clk);
        dvd_d[0] = 32'd50;
        dvd_v[0] = 1'b1;
        push(32'd5, 64'h0000000A_00000000);
        @(posedge clk);
        #1 dvd_d[0] = 32'd999;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("stag_wait_rdy", 64'({dvd_r[0], dvs_r[0]}), 64'd1);
        end
        @(negedge clk);
        dvs_d[0] = 32'd5;
        dvs_v[0] = 1'b1;
        @(posedge clk);
        #1 idle(0);
        wait_result(0, "stag", t);
        post_done(0, "stag");

        // Abort in the middle of RUN
        @(negedge clk);
        drive(0, 32'd1000, 32'd3);
        @(posedge clk);
        #1 idle(0);
        repeat (10) @(posedge clk);
        #1 resetn = 1'b0;
        @(negedge clk);
        check("abort_rdy", 64'({dvd_r[0], dvs_r[0]}), 64'd3);
        check("abort_valid", 64'(dout_v[0]), 64'd0);
        check("abort_dout", dout_d[0], 64'd0);
        @(posedge clk);
        #1 resetn = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (dout_v[0]) seen = 1'b1;
        end
        check("abort_no_output", 64'(seen), 64'd0);
        op(0, 32'd9, 32'd3, 64'h00000003_00000000, "post_abort");

        // Back-to-back with operands offered continuously
        ba[0] = 32'hFFFF_FF9C; bb[0] = 32'd7;
        ba[1] = 32'd1000;      bb[1] = 32'hFFFF_FFF6;
        ba[2] = 32'd7;         bb[2] = 32'hFFFF_FFFE;
        tprev = 0;
        @(negedge clk);
        drive(1, ba[0], bb[0]);
        push(bb[0], model(1, ba[0], bb[0]));
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            if (k < 2) begin
                drive(1, ba[k+1], bb[k+1]);
                push(bb[k+1], model(1, ba[k+1], bb[k+1]));
            end else begin
                idle(1);
            end
            wait_result(1, "b2b", t);
            if (k > 0) check("b2b_gap", 64'(t - tprev), 64'd34);
            tprev = t;
            if (k < 2) begin
                @(negedge clk);
                check("b2b_rdy", 64'({dvd_r[1], dvs_r[1]}), 64'd3);
            end else begin
                post_done(1, "b2b_last");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iter_divider.md
ITER_DIVIDER -- requirements
Module: iter_divider

Interface
REQ-001 The block SHALL have parameter SIGNED, default 0, where 0 selects unsigned division and 1 selects two's-complement signed division.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port s_axis_dividend_tdata, input, 32 bits: the dividend.
REQ-005 The block SHALL have port s_axis_dividend_tvalid, input, 1 bit: the dividend is offered.
REQ-006 The block SHALL have port s_axis_dividend_tready, output, 1 bit: the dividend can be accepted.
REQ-007 The block SHALL have port s_axis_divisor_tdata, input, 32 bits: the divisor.
REQ-008 The block SHALL have port s_axis_divisor_tvalid, input, 1 bit: the divisor is offered.
REQ-009 The block SHALL have port s_axis_divisor_tready, output, 1 bit: the divisor can be accepted.
REQ-010 The block SHALL have port m_axis_dout_tdata, output, 64 bits: {quotient[63:32], remainder[31:0]}.
REQ-011 The block SHALL have port m_axis_dout_tvalid, output, 1 bit: the result is valid; there is no tready.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE.
REQ-013 In IDLE, each input channel SHALL be independent: its tready is high until that channel's operand is captured on a tvalid&&tready edge, then low.
REQ-014 Operands MAY arrive in the same cycle or in any order, with arbitrary spacing between them.
REQ-015 On the edge that completes the second capture, the block SHALL enter RUN with a 6-bit iteration counter of 0.
REQ-016 In RUN, one restoring radix-2 iteration SHALL run per cycle on 32-bit magnitudes with a 33-bit partial remainder.
REQ-017 The block SHALL leave RUN for DONE after iteration 31.
REQ-018 Both trready outputs SHALL be low throughout RUN and DONE.
REQ-019 DONE SHALL last one cycle with m_axis_dout_tvalid=1, and the block SHALL then return to IDLE.
REQ-020 Both trready outputs SHALL be 1 in the first IDLE cycle after DONE.
REQ-021 Latency: m_axis_dout_tvalid SHALL be high exactly in the 33rd cycle after the second-capture edge, for exactly 1 cycle.
REQ-022 m_axis_dout_tdata SHALL hold its value until the next DONE, so a requester that samples it late reads a stable result.
REQ-023 With SIGNED=1, the operand magnitudes SHALL be divided; quotient sign = dividend sign XOR divisor sign, and remainder sign = dividend sign.
REQ-024 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0.
REQ-025 For a divisor of 0, in both modes, the quotient SHALL be 0xFFFFFFFF, the remainder SHALL equal the dividend, and the latency SHALL be unchanged.
REQ-026 tvalid on an input while that channel is not ready SHALL be ignored, and the data SHALL NOT be sampled.

Reset
REQ-027 On resetn=0, the block SHALL immediately enter IDLE, including mid-RUN or in DONE.
REQ-028 On resetn=0, both tready outputs SHALL be 1, m_axis_dout_tvalid SHALL be 0, m_axis_dout_tdata SHALL be 0, the captured flags SHALL be cleared and the counter SHALL be 0.
REQ-029 An operation aborted by reset SHALL produce no output.
REQ-030 The first capture SHALL be possible on the first edge after resetn deasserts.

Configuration
REQ-031 With macro DIV_DBZ_FLAG_EN defined, the block SHALL add output m_axis_dout_tuser (1 bit), equal to 1 in DONE when the captured divisor was 0, and 0 otherwise and at reset.
REQ-032 Without DIV_DBZ_FLAG_EN, the port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-033 Shared package div_pkg SHALL hold the FSM state type (IDLE/RUN/DONE), DIV_W=32, DIV_ITERS=32, CNT_W=6 and the division-by-zero quotient constant 0xFFFFFFFF.
REQ-034 Sub-module div_iter_step SHALL implement one combinational restoring step: {33-bit partial remainder, 32-bit quotient shift, divisor} -> next {partial remainder, quotient}.
REQ-035 Two top-level instances SHALL exist, SIGNED=0 and SIGNED=1, feeding the divu and div paths respectively.

Verification
REQ-036 Unsigned: dividend 100, divisor 7 in the same cycle -> dout 0x0000000E_00000002, tvalid high exactly 33 cycles later for 1 cycle.
REQ-037 Signed: dividend 0xFFFFFFF9 (-7), divisor 2 -> dout 0xFFFFFFFD_FFFFFFFF; then 0x80000000 / 0xFFFFFFFF -> 0x80000000_00000000.
REQ-038 Division by zero, both modes: 0x12345678 / 0 -> 0xFFFFFFFF_12345678; with DIV_DBZ_FLAG_EN defined, tuser=1 in the DONE cycle.
REQ-039 Staggered: dividend 50 captured, divisor tvalid 5 cycles later with 5 -> dividend_tready low after the first capture, result 0x0000000A_00000000, latency counted from the divisor edge; a dividend re-offered while waiting is not captured.
REQ-040 Reset mid-RUN at iteration 10 -> no tvalid, both tready 1 during reset; next 9/3 after release -> 0x00000003_00000000 with full latency.
REQ-041 Back-to-back: new operands offered continuously -> tready returns in the cycle after DONE, consecutive results 34 cycles apart, each correct.
